// File: rtl/dance_input_conditioner.sv
// dance_input_conditioner
// Front end for the two player processors. It parses the PS2 scancode stream
// (E0 prefixes, F0 break codes), suppresses typematic auto-repeat, and
// debounces the two shake sensors. It emits one-cycle arrow events per player
// and a game-reset request.
module dance_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  input  logic       shake1_in,
  input  logic       shake2_in,
  output logic       p1_key_pressed,
  output logic [7:0] p1_arrow,
  output logic       p2_key_pressed,
  output logic [7:0] p2_arrow,
  output logic       game_reset_req,
  output logic [7:0] held_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       CODE_SHAKE = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_GOT_E0, S_GOT_F0, S_GOT_E0F0} state_t;

  // Returns {mapped, player, key index}; key index 0..3 = up/left/down/right.
  function automatic logic [3:0] decode_key(input logic [7:0] b);
    case (b)
      8'h1D:   decode_key = 4'b1000;
      8'h1C:   decode_key = 4'b1001;
      8'h1B:   decode_key = 4'b1010;
      8'h23:   decode_key = 4'b1011;
      8'h75:   decode_key = 4'b1100;
      8'h6B:   decode_key = 4'b1101;
      8'h72:   decode_key = 4'b1110;
      8'h74:   decode_key = 4'b1111;
      default: decode_key = 4'b0000;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic       w_make, w_break;
  logic [3:0] w_dec;
  logic [2:0] w_code;
  logic [1:0] w_key_evt;
  logic [7:0] r_held;
  logic       r_game_reset;

  logic [1:0]       r_sync1, r_sync2, r_stable, r_stable_q;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       w_shk_evt;

  logic [1:0] r_strobe, r_shk_pend, r_key_pend;
  logic [2:0] r_arrow [2];
  logic [2:0] r_kpc   [2];
  logic [1:0] w_strobe_nxt, w_shk_pend_nxt, w_key_pend_nxt;
  logic [2:0] w_arrow_nxt [2];
  logic [2:0] w_kpc_nxt   [2];

  // Parser state register; reset drops any partially received code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Parser next state: classifies the final byte of a code as make or break.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    if (ps2_key_pressed) begin
      case (r_state)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0)      w_state_nxt = S_GOT_E0;
          else if (ps2_key_data == 8'hF0) w_state_nxt = S_GOT_F0;
          else                            w_make      = 1'b1;
        end
        S_GOT_E0: begin
          if (ps2_key_data == 8'hF0) w_state_nxt = S_GOT_E0F0;
          else begin
            w_make      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_break     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_dec  = decode_key(ps2_key_data);
  assign w_code = {1'b0, w_dec[1:0]} + 3'd1;

  // A make of a key that is not already held is a new event for its player.
  always_comb begin
    w_key_evt = 2'b00;
    if (w_make && w_dec[3] && !r_held[w_dec[2:0]]) w_key_evt[w_dec[2]] = 1'b1;
  end

  // Held-key mask and game-reset request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_held       <= 8'h00;
      r_game_reset <= 1'b0;
    end else begin
      r_game_reset <= w_make && (ps2_key_data == 8'h2D);
      if (w_make && w_dec[3])       r_held[w_dec[2:0]] <= 1'b1;
      else if (w_break && w_dec[3]) r_held[w_dec[2:0]] <= 1'b0;
    end
  end

  // Shake synchronisers and debounce: a level must persist DEBOUNCE_CYCLES.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1    <= 2'b00;
      r_sync2    <= 2'b00;
      r_stable   <= 2'b00;
      r_stable_q <= 2'b00;
      for (int p = 0; p < 2; p++) r_cnt[p] <= '0;
    end else begin
      r_sync1    <= {shake2_in, shake1_in};
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      for (int p = 0; p < 2; p++) begin
        if (r_sync2[p] == r_stable[p]) begin
          r_cnt[p] <= '0;
        end else if (r_cnt[p] == CNT_MAX) begin
          r_stable[p] <= r_sync2[p];
          r_cnt[p]    <= '0;
        end else begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end
      end
    end
  end

  assign w_shk_evt = r_stable & ~r_stable_q;

  // Event arbitration: pending shake, then pending key, then new key, then new shake.
  always_comb begin
    w_strobe_nxt   = 2'b00;
    w_shk_pend_nxt = r_shk_pend;
    w_key_pend_nxt = r_key_pend;
    for (int p = 0; p < 2; p++) begin
      w_arrow_nxt[p] = r_arrow[p];
      w_kpc_nxt[p]   = r_kpc[p];
      if (r_shk_pend[p] || r_key_pend[p]) begin
        w_strobe_nxt[p] = 1'b1;
        if (r_shk_pend[p]) begin
          w_arrow_nxt[p]    = CODE_SHAKE;
          w_shk_pend_nxt[p] = 1'b0;
        end else begin
          w_arrow_nxt[p]    = r_kpc[p];
          w_key_pend_nxt[p] = 1'b0;
        end
        if (w_key_evt[p]) begin
          w_key_pend_nxt[p] = 1'b1;
          w_kpc_nxt[p]      = w_code;
        end
        if (w_shk_evt[p]) w_shk_pend_nxt[p] = 1'b1;
      end else if (w_key_evt[p]) begin
        w_strobe_nxt[p] = 1'b1;
        w_arrow_nxt[p]  = w_code;
        if (w_shk_evt[p]) w_shk_pend_nxt[p] = 1'b1;
      end else if (w_shk_evt[p]) begin
        w_strobe_nxt[p] = 1'b1;
        w_arrow_nxt[p]  = CODE_SHAKE;
      end
    end
  end

  // Registered event outputs and pending slots.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_strobe   <= 2'b00;
      r_shk_pend <= 2'b00;
      r_key_pend <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        r_arrow[p] <= 3'b000;
        r_kpc[p]   <= 3'b000;
      end
    end else begin
      r_strobe   <= w_strobe_nxt;
      r_shk_pend <= w_shk_pend_nxt;
      r_key_pend <= w_key_pend_nxt;
      for (int p = 0; p < 2; p++) begin
        r_arrow[p] <= w_arrow_nxt[p];
        r_kpc[p]   <= w_kpc_nxt[p];
      end
    end
  end

  assign p1_key_pressed = r_strobe[0];
  assign p2_key_pressed = r_strobe[1];
  assign p1_arrow       = {5'b00000, r_arrow[0]};
  assign p2_arrow       = {5'b00000, r_arrow[1]};
  assign game_reset_req = r_game_reset;
  assign held_mask      = r_held;

endmodule

// File: doc/dance_input_conditioner.md
Name: dance_input_conditioner

Overview:
- Upstream stage between the PS2 keyboard interface / shake sensors and the two player processors.
- Parses the raw PS2 scancode byte stream, including E0 extended prefixes and F0 break codes, and suppresses typematic auto-repeat.
- Debounces and synchronises the two asynchronous shake inputs.
- Emits, per player, a registered one-cycle key_pressed strobe with a 3-bit arrow code, plus a one-cycle game-reset request.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised shake level must stay stable before it is accepted (50 ms at 10 MHz).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock (10 MHz PLL output).
- reset  input  1  asynchronous, active-high reset.
- ps2_key_pressed  input  1  one-cycle strobe: new byte valid on ps2_key_data.
- ps2_key_data  input  8  raw scancode byte.
- shake1_in  input  1  raw asynchronous player-1 shake sensor.
- shake2_in  input  1  raw asynchronous player-2 shake sensor.
- p1_key_pressed  output  1  one-cycle event strobe, player 1.
- p1_arrow  output  8  [2:0] event code, [7:3] always 0.
- p2_key_pressed  output  1  one-cycle event strobe, player 2.
- p2_arrow  output  8  [2:0] event code, [7:3] always 0.
- game_reset_req  output  1  one-cycle pulse on make of scancode 2D.
- held_mask  output  8  currently held arrow keys: [3:0] player 1 up/left/down/right, [7:4] player 2 in the same order.

Behaviour:
- Reset: all outputs 0, parser state IDLE, held_mask 0, sync flops 0, debounce counters 0, stable shake levels 0, pending flags 0. Reset mid-sequence (for example in E0F0) discards the partial code.
- Arrow codes: up 001, left 010, down 011, right 100, shake 101.
  - Player 1 keys: 1D, 1C, 1B, 23.
  - Player 2 keys: 75, 6B, 72, 74.
- Parser FSM advances only on cycles where ps2_key_pressed=1:
  - IDLE: byte E0 -> GOT_E0; byte F0 -> GOT_F0; any other byte -> make(byte), stay in IDLE.
  - GOT_E0: byte F0 -> GOT_E0F0; any other byte -> make(byte), go to IDLE.
  - GOT_F0 / GOT_E0F0: any byte -> break(byte), go to IDLE.
  - The E0 prefix does not change the mapping; only the final byte is decoded.
- make(byte):
  - Unmapped bytes are ignored.
  - 2D -> game_reset_req=1 on the next cycle.
  - Mapped arrow with held bit already 1 -> suppressed (auto-repeat).
  - Mapped arrow with held bit 0 -> set the held bit; the player's key_pressed=1 and arrow code appear on the next cycle (latency 1).
- break(byte): clears the corresponding held bit; no event is emitted. Breaking a key that is not held has no effect.
- Shake path, per player:
  - 2-flop synchroniser, then debounce counter.
  - Counter clears whenever the synchronised level equals the stable level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
  - A 0->1 change of the stable level raises a shake event, code 101.
  - Latency from a clean raw edge to the strobe: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Collision, same player, same cycle, key event and shake event:
  - The key event is emitted first.
  - The shake is latched into a 1-entry pending flag and emitted on the following cycle.
  - A pending shake has priority over a new key event arriving that cycle; that key event is then held in a 1-entry key-pending register.
  - Debounce guarantees no second shake within 2 cycles.
- Strobes are never asserted on two consecutive cycles except in the collision case.
- arrow outputs hold their last value when the strobe is 0. They are only meaningful while the strobe is 1.
- Players are fully independent; both players' strobes may assert in the same cycle (the shake path for one player, the keyboard path for the other).

Test Plan:
- Byte 1D -> p1_key_pressed=1 for exactly 1 cycle with p1_arrow=8'h01, held_mask=8'h01. Repeated 1D bytes -> no strobes. Bytes F0,1D -> held_mask=0. Next 1D -> strobe again.
- Bytes E0,75 -> p2 strobe, p2_arrow=8'h01, held_mask[4]=1. Bytes E0,F0,75 -> no strobe, held_mask[4]=0. Bytes F0,6B with 6B not held -> no strobe.
- shake1_in high for DEBOUNCE_CYCLES-10 cycles (sim DEBOUNCE_CYCLES=16) -> no strobe. Held high for 40 cycles -> exactly one p1 strobe with p1_arrow=8'h05, strobe at raw-edge cycle + 19. Falling edge -> no strobe.
- p1 shake stable edge in the same cycle as a 23 make byte -> cycle N: p1_arrow=8'h04; cycle N+1: p1_arrow=8'h05.
- Byte 2D -> game_reset_req=1 for 1 cycle; no player strobes.
- Reset asserted after bytes E0,F0 and before the final byte, with held_mask=8'h11 -> after release, byte 75 -> make (strobe), held_mask=8'h10.
